// File: rtl/step_dir_pkg.sv
// step_dir_pkg: shared constants and snapshot state encoding for the step/dir receiver.
package step_dir_pkg;
    localparam logic DIR_INC  = 1'b1;
    localparam logic DIR_DEC  = 1'b0;
    localparam logic PUL_IDLE = 1'b1;
    localparam int POS_W_DEF      = 16;
    localparam int DIR_SETUP_DEF  = 4;
    localparam int MIN_PERIOD_DEF = 8;
    localparam int TMR_W_DEF      = 8;
    typedef enum logic [1:0] {SNAP_IDLE, SNAP_ARMED, SNAP_LATCHED} snap_state_e;
endpackage

// File: rtl/step_axis_rx.sv
// step_axis_rx: one axis of the step/dir receiver: sync, edge detect, position, timing checks.
module step_axis_rx import step_dir_pkg::*; #(
    parameter int POS_W      = POS_W_DEF,
    parameter int DIR_SETUP  = DIR_SETUP_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int TMR_W      = TMR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             pul_i,
    input  logic             dir_i,
    output logic [POS_W-1:0] pos_o,
    output logic [POS_W-1:0] pos_d_o,
    output logic             step_o,
    output logic             err_setup_o,
    output logic             err_rate_o,
    output logic             err_ovf_o
);
    localparam logic [TMR_W-1:0] DS    = TMR_W'(DIR_SETUP);
    localparam logic [TMR_W-1:0] MP    = TMR_W'(MIN_PERIOD);
    localparam logic [POS_W-1:0] P_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic [POS_W-1:0] P_MIN = {1'b1, {(POS_W-1){1'b0}}};
    logic [2:0] pul_q, dir_q;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [TMR_W-1:0] dtmr_q, dtmr_d, ptmr_q, ptmr_d;
    logic step_q, step_d, es_q, es_d, er_q, er_d, eo_q, eo_d;
    logic step_ev, dir_chg, inc, ovf_ev;
    // [1] is the synchronised level, [2] its previous value for edge detection
    assign step_ev = pul_q[2] & ~pul_q[1];
    assign dir_chg = dir_q[2] ^ dir_q[1];
    assign inc     = dir_q[1] == DIR_INC;
    assign ovf_ev  = step_ev & (inc ? pos_q == P_MAX : pos_q == P_MIN);
    always_comb begin
        pos_d  = clr_i ? '0 : step_ev ? (inc ? pos_q + POS_W'(1) : pos_q - POS_W'(1)) : pos_q;
        dtmr_d = clr_i ? DS : dir_chg ? '0 : dtmr_q < DS ? dtmr_q + TMR_W'(1) : dtmr_q;
        ptmr_d = clr_i ? MP : step_ev ? '0 : ptmr_q < MP ? ptmr_q + TMR_W'(1) : ptmr_q;
        step_d = ~clr_i & step_ev;
        es_d   = ~clr_i & (es_q | (step_ev & (dir_chg | dtmr_q < DS)));
        er_d   = ~clr_i & (er_q | (step_ev & ptmr_q < MP));
        eo_d   = ~clr_i & (eo_q | ovf_ev);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pul_q  <= {3{PUL_IDLE}};
            dir_q  <= '0;
            pos_q  <= '0;
            dtmr_q <= DS;
            ptmr_q <= MP;
            step_q <= 1'b0;
            es_q   <= 1'b0;
            er_q   <= 1'b0;
            eo_q   <= 1'b0;
        end else begin
            pul_q  <= {pul_q[1:0], pul_i};
            dir_q  <= {dir_q[1:0], dir_i};
            pos_q  <= pos_d;
            dtmr_q <= dtmr_d;
            ptmr_q <= ptmr_d;
            step_q <= step_d;
            es_q   <= es_d;
            er_q   <= er_d;
            eo_q   <= eo_d;
        end
    end
    assign pos_o       = pos_q;
    assign pos_d_o     = pos_d;
    assign step_o      = step_q;
    assign err_setup_o = es_q;
    assign err_rate_o  = er_q;
    assign err_ovf_o   = eo_q;
endmodule

// File: rtl/step_dir_decoder.sv
// step_dir_decoder: two-axis step/dir receiver with position counters, timing checks and stop snapshot.
module step_dir_decoder import step_dir_pkg::*; #(
    parameter int POS_W      = POS_W_DEF,
    parameter int DIR_SETUP  = DIR_SETUP_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int TMR_W      = TMR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pul1,
    input  logic             pul2,
    input  logic             dir1,
    input  logic             dir2,
    input  logic             stop,
    input  logic             clr,
    output logic [POS_W-1:0] pos1,
    output logic [POS_W-1:0] pos2,
    output logic [1:0]       step_seen,
    output logic [POS_W-1:0] snap1,
    output logic [POS_W-1:0] snap2,
    output logic             done,
    output logic [1:0]       err_setup,
    output logic [1:0]       err_rate,
    output logic [1:0]       err_ovf
);
    logic [1:0] pul_w, dir_w;
    logic [POS_W-1:0] pos_w [2];
    logic [POS_W-1:0] pos_nx [2];
    logic [2:0] stop_q;
    logic stop_rise, stop_fall;
    logic [POS_W-1:0] snap1_q, snap2_q;
    snap_state_e state_q, state_d;
    assign pul_w = {pul2, pul1};
    assign dir_w = {dir2, dir1};
    for (genvar g = 0; g < 2; g++) begin : g_axis
        step_axis_rx #(
            .POS_W(POS_W), .DIR_SETUP(DIR_SETUP), .MIN_PERIOD(MIN_PERIOD), .TMR_W(TMR_W)
        ) u_axis (
            .clk(clk), .rst(rst), .clr_i(clr), .pul_i(pul_w[g]), .dir_i(dir_w[g]),
            .pos_o(pos_w[g]), .pos_d_o(pos_nx[g]), .step_o(step_seen[g]),
            .err_setup_o(err_setup[g]), .err_rate_o(err_rate[g]), .err_ovf_o(err_ovf[g])
        );
    end
    assign stop_rise = stop_q[1] & ~stop_q[2];
    assign stop_fall = ~stop_q[1] & stop_q[2];
    always_comb begin
        state_d = clr ? SNAP_IDLE
                : state_q == SNAP_IDLE  ? (stop_q[1] ? SNAP_IDLE : SNAP_ARMED)
                : state_q == SNAP_ARMED ? (stop_rise ? SNAP_LATCHED : SNAP_ARMED)
                : stop_fall ? SNAP_ARMED : SNAP_LATCHED;
    end
    // Snapshot takes next-state positions so a step counted in the latch cycle is included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_q  <= '0;
            state_q <= SNAP_IDLE;
            snap1_q <= '0;
            snap2_q <= '0;
        end else begin
            stop_q  <= {stop_q[1:0], stop};
            state_q <= state_d;
            if (clr) begin
                snap1_q <= '0;
                snap2_q <= '0;
            end else if (state_q == SNAP_ARMED && stop_rise) begin
                snap1_q <= pos_nx[0];
                snap2_q <= pos_nx[1];
            end
        end
    end
    assign pos1  = pos_w[0];
    assign pos2  = pos_w[1];
    assign snap1 = snap1_q;
    assign snap2 = snap2_q;
    assign done  = state_q == SNAP_LATCHED;
endmodule

// File: tb/tb_step_dir_decoder.sv
// tb_step_dir_decoder: directed checks of counting, snapshot, timing flags, wrap and reset.
module tb_step_dir_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pul1 = 1'b1, pul2 = 1'b1, dir1 = 1'b0, dir2 = 1'b0, stop = 1'b0, clr = 1'b0;
    logic [15:0] pos1, pos2, snap1, snap2;
    logic [1:0] step_seen, err_setup, err_rate, err_ovf;
    logic done;
    logic [7:0] s_pos1, s_pos2, s_snap1, s_snap2;
    logic [1:0] s_step_seen, s_err_setup, s_err_rate, s_err_ovf;
    logic s_done;
    int checks = 0, failures = 0;
    int seen0 = 0, seen1 = 0;

    always #5 clk = ~clk;

    step_dir_decoder dut (
        .clk(clk), .rst(rst), .pul1(pul1), .pul2(pul2), .dir1(dir1), .dir2(dir2),
        .stop(stop), .clr(clr), .pos1(pos1), .pos2(pos2), .step_seen(step_seen),
        .snap1(snap1), .snap2(snap2), .done(done), .err_setup(err_setup),
        .err_rate(err_rate), .err_ovf(err_ovf)
    );

    // Narrow instance sharing the same pins, so the wrap boundary is reachable quickly
    step_dir_decoder #(.POS_W(8)) u_small (
        .clk(clk), .rst(rst), .pul1(pul1), .pul2(pul2), .dir1(dir1), .dir2(dir2),
        .stop(stop), .clr(clr), .pos1(s_pos1), .pos2(s_pos2), .step_seen(s_step_seen),
        .snap1(s_snap1), .snap2(s_snap2), .done(s_done), .err_setup(s_err_setup),
        .err_rate(s_err_rate), .err_ovf(s_err_ovf)
    );

    always @(negedge clk) begin
        if (step_seen[0]) seen0++;
        if (step_seen[1]) seen1++;
    end

    task automatic step_pair(input logic m1, input logic m2, input logic d1, input logic d2);
        @(posedge clk); #1 dir1 = d1; dir2 = d2;
        repeat (6) @(posedge clk);
        #1 pul1 = ~m1; pul2 = ~m2;
        repeat (7) @(posedge clk);
        #1 pul1 = 1'b1; pul2 = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic do_clr;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (pos1 !== 16'd0 || pos2 !== 16'd0) begin failures++; $display("FAIL reset_pos got=%h/%h exp=0/0", pos1, pos2); end
        checks++; if (snap1 !== 16'd0 || snap2 !== 16'd0 || done !== 1'b0) begin failures++; $display("FAIL reset_snap got=%h/%h/%b exp=0/0/0", snap1, snap2, done); end
        checks++; if ({step_seen, err_setup, err_rate, err_ovf} !== 8'd0) begin failures++; $display("FAIL reset_flags got=%b exp=0", {step_seen, err_setup, err_rate, err_ovf}); end
    endtask

    task automatic test_latency;
        @(posedge clk); #1 dir1 = 1'b1;
        repeat (8) @(posedge clk);
        #1 pul1 = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++; if (pos1 !== 16'd0 || step_seen !== 2'b00) begin failures++; $display("FAIL latency_early got=%h/%b exp=0000/00", pos1, step_seen); end
        @(negedge clk);
        checks++; if (pos1 !== 16'd1 || step_seen !== 2'b01) begin failures++; $display("FAIL latency_hit got=%h/%b exp=0001/01", pos1, step_seen); end
        @(negedge clk);
        checks++; if (pos1 !== 16'd1 || step_seen !== 2'b00) begin failures++; $display("FAIL latency_strobe got=%h/%b exp=0001/00", pos1, step_seen); end
        pul1 = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    task automatic test_count;
        int b;
        do_clr();
        @(negedge clk);
        checks++; if (pos1 !== 16'd0) begin failures++; $display("FAIL clr_pos got=%h exp=0000", pos1); end
        b = seen0;
        for (int i = 0; i < 100; i++) step_pair(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (pos1 !== 16'd100) begin failures++; $display("FAIL count_pos got=%0d exp=100", pos1); end
        checks++; if (seen0 - b !== 100) begin failures++; $display("FAIL count_strobes got=%0d exp=100", seen0 - b); end
        checks++; if ({err_setup, err_rate, err_ovf} !== 6'd0 || pos2 !== 16'd0) begin failures++; $display("FAIL count_errs got=%b pos2=%h exp=0", {err_setup, err_rate, err_ovf}, pos2); end
    endtask

    task automatic test_circle;
        int b;
        do_clr();
        for (int i = 0; i < 62; i++) step_pair(1'b1, 1'b0, 1'b1, 1'b0);
        b = seen1;
        for (int i = 0; i < 62; i++) step_pair(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 62; i++) step_pair(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 62; i++) step_pair(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 62; i++) step_pair(1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (pos1 !== 16'd62 || pos2 !== 16'd0) begin failures++; $display("FAIL circle_pos got=%0d/%0d exp=62/0", pos1, pos2); end
        checks++; if (seen1 - b !== 248) begin failures++; $display("FAIL circle_strobes got=%0d exp=248", seen1 - b); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL circle_predone got=%b exp=0", done); end
        @(posedge clk); #1 stop = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b1 || snap1 !== 16'd62 || snap2 !== 16'd0) begin failures++; $display("FAIL circle_snap got=%b/%0d/%0d exp=1/62/0", done, snap1, snap2); end
        checks++; if ({err_setup, err_rate, err_ovf} !== 6'd0) begin failures++; $display("FAIL circle_errs got=%b exp=0", {err_setup, err_rate, err_ovf}); end
        step_pair(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checks++; if (pos1 !== 16'd63 || snap1 !== 16'd62 || done !== 1'b1) begin failures++; $display("FAIL latched_step got=%0d/%0d/%b exp=63/62/1", pos1, snap1, done); end
        @(posedge clk); #1 stop = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0 || snap1 !== 16'd62) begin failures++; $display("FAIL stop_fall got=%b/%0d exp=0/62", done, snap1); end
    endtask

    task automatic test_setup;
        do_clr();
        @(posedge clk); #1 dir2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 pul2 = 1'b0;
        repeat (6) @(posedge clk);
        #1 pul2 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (err_setup !== 2'b10) begin failures++; $display("FAIL setup_flag got=%b exp=10", err_setup); end
        checks++; if (pos2 !== 16'hFFFF || err_rate !== 2'b00) begin failures++; $display("FAIL setup_pos got=%h/%b exp=ffff/00", pos2, err_rate); end
    endtask

    task automatic test_rate;
        do_clr();
        @(posedge clk); #1 dir1 = 1'b1;
        repeat (8) @(posedge clk);
        #1 pul1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 pul1 = 1'b1;
        repeat (2) @(posedge clk);
        #1 pul1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 pul1 = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (err_rate !== 2'b01 || pos1 !== 16'd2) begin failures++; $display("FAIL rate_flag got=%b/%0d exp=01/2", err_rate, pos1); end
        repeat (12) @(posedge clk);
        #1 pul1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 pul1 = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (err_rate !== 2'b01 || pos1 !== 16'd3 || err_setup !== 2'b00) begin failures++; $display("FAIL rate_sticky got=%b/%0d/%b exp=01/3/00", err_rate, pos1, err_setup); end
        do_clr();
        @(negedge clk);
        checks++; if (err_rate !== 2'b00 || pos1 !== 16'd0) begin failures++; $display("FAIL rate_clr got=%b/%0d exp=00/0", err_rate, pos1); end
    endtask

    task automatic test_ovf;
        do_clr();
        for (int i = 0; i < 127; i++) step_pair(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (s_pos1 !== 8'h7F || s_pos2 !== 8'h81 || s_err_ovf !== 2'b00) begin failures++; $display("FAIL ovf_pre got=%h/%h/%b exp=7f/81/00", s_pos1, s_pos2, s_err_ovf); end
        step_pair(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (s_pos1 !== 8'h80 || s_pos2 !== 8'h80 || s_err_ovf !== 2'b01) begin failures++; $display("FAIL ovf_inc got=%h/%h/%b exp=80/80/01", s_pos1, s_pos2, s_err_ovf); end
        step_pair(1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (s_pos1 !== 8'h81 || s_pos2 !== 8'h7F || s_err_ovf !== 2'b11) begin failures++; $display("FAIL ovf_dec got=%h/%h/%b exp=81/7f/11", s_pos1, s_pos2, s_err_ovf); end
        checks++; if (pos1 !== 16'd129 || pos2 !== 16'hFF7F || err_ovf !== 2'b00) begin failures++; $display("FAIL ovf_wide got=%h/%h/%b exp=0081/ff7f/00", pos1, pos2, err_ovf); end
    endtask

    task automatic test_rst_mid;
        int b;
        @(posedge clk); #1 pul1 = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (pos1 !== 16'd0 || pos2 !== 16'd0 || s_pos1 !== 8'd0) begin failures++; $display("FAIL rst_async got=%h/%h/%h exp=0", pos1, pos2, s_pos1); end
        b = seen0;
        pul1 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (pos1 !== 16'd0 || seen0 !== b) begin failures++; $display("FAIL rst_mid got=%h/%0d exp=0000/0", pos1, seen0 - b); end
        checks++; if ({done, err_setup, err_rate, err_ovf} !== 7'd0) begin failures++; $display("FAIL rst_flags got=%b exp=0", {done, err_setup, err_rate, err_ovf}); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_count();
        test_circle();
        test_setup();
        test_rate();
        test_ovf();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/step_dir_decoder.md
Name: step_dir_decoder

Overview:
- Receive end of the two-axis step/direction interface that the interpolators (line, circle) drive on pul1/pul2/dir1/dir2.
- Synchronises the asynchronous step/dir lines and counts step edges into signed per-axis position registers.
- Checks timing rules (direction setup, minimum step period) and flags violations.
- Latches a snapshot of both positions when the source's stop goes high. Used as an in-fabric position monitor / closed-loop check and as the verification scoreboard source.

Parameters:
- POS_W, 16, width of signed position counters (matches interpolator site_x/site_y).
- DIR_SETUP, 4, minimum clk cycles dir must be stable (post-sync) before a counted step edge.
- MIN_PERIOD, 8, minimum clk cycles between two counted step edges on the same axis.
- TMR_W, 8, width of per-axis interval timers; must hold max(DIR_SETUP, MIN_PERIOD).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- pul1  in  1  axis-1 step line, asynchronous.
- pul2  in  1  axis-2 step line, asynchronous.
- dir1  in  1  axis-1 direction: 1 = increment, 0 = decrement.
- dir2  in  1  axis-2 direction, same encoding.
- stop  in  1  source "motion finished" level, asynchronous.
- clr  in  1  synchronous clear of positions, flags, snapshot.
- pos1  out  POS_W  signed axis-1 position.
- pos2  out  POS_W  signed axis-2 position.
- step_seen  out  2  one-cycle strobe per axis when a step is counted (bit0 = axis 1).
- snap1  out  POS_W  axis-1 position latched at stop rise.
- snap2  out  POS_W  axis-2 position latched at stop rise.
- done  out  1  high from the stop-rise snapshot until clr or stop low.
- err_setup  out  2  sticky: step edge while dir changed less than DIR_SETUP cycles earlier.
- err_rate  out  2  sticky: step edge less than MIN_PERIOD cycles after the previous one.
- err_ovf  out  2  sticky: position wrapped past the signed range.

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset and clr give identical results: all outputs 0. Synchroniser stages reset to pul=1, dir=0, stop=0, which matches the source idle state (px=py=1), so no false edge is detected after reset.
- Sync: each of pul1, pul2, dir1, dir2, stop passes through 2 flip-flops. A third flop holds the previous value for edge detect.
- Step event: falling edge (1->0) of the synchronised pul. The source updates its coordinate on that transition. Latency from the pin to pos update and the step_seen strobe is 3 clk cycles.
- Position update on a step event: dir=1 gives +1, dir=0 gives -1, using the synchronised dir sampled in the same cycle.
- Wrap-around: two's-complement wrap. +max to -min, or -min to +max, sets the err_ovf bit for that axis.
- Dir timer: resets to 0 on any synchronised dir change and saturates at DIR_SETUP. A step event while the timer is below DIR_SETUP sets err_setup. The step is still counted.
- Period timer: resets to 0 on each step event and saturates at MIN_PERIOD. A step event while the timer is below MIN_PERIOD sets err_rate. The step is still counted. The first step after reset/clr is exempt (timer starts saturated).
- Simultaneous steps on both axes are independent and both are counted in the same cycle.
- Snapshot FSM, per the states below:
  - IDLE -> ARMED when synchronised stop is 0.
  - ARMED -> LATCHED on stop rising edge. In that cycle snap1/snap2 take pos1/pos2 including any same-cycle step, and done goes to 1.
  - LATCHED -> ARMED when stop falls, with done cleared.
  - clr returns the FSM to IDLE from any state.
- Steps arriving while LATCHED still update pos1/pos2 but not the snapshot.
- clr takes priority over a same-cycle step event: the step is dropped.
- rst mid-operation: immediate asynchronous clear. No pending edge survives because the synchroniser is reset to idle levels.

Decomposition:
- Package step_dir_pkg holds: DIR_INC=1 and DIR_DEC=0; PUL_IDLE=1; default POS_W/DIR_SETUP/MIN_PERIOD; snapshot FSM state encoding (IDLE, ARMED, LATCHED).
- Sub-module step_axis_rx, instantiated twice. It contains the synchroniser, edge detect, position counter, both timers and that axis's three sticky flags.
- The top level holds the stop synchroniser, the snapshot FSM and the output muxing.

Test Plan:
- After reset, drive pul1 idle high, then 100 falling edges with dir1=1, spaced 20 cycles -> pos1=100, step_seen[0] pulses 100 times, all errors 0.
- Full 4-quadrant circle stimulus with radius 62 steps from (62,0), then assert stop -> done=1, snap1=62, snap2=0, no errors.
- Toggle dir2 and then a pul2 falling edge 2 cycles later -> err_setup[1]=1 and pos2 still changes by 1; err_setup[0] stays 0.
- Two pul1 falling edges 4 cycles apart -> err_rate[0]=1. A third edge 20 cycles later does not clear the flag; clr does clear it.
- Preload pos1 to 32767 via 32767 increments, then one more increment -> pos1=-32768 and err_ovf[0]=1.
- Assert rst asynchronously mid-pulse, between a pul1 fall and the counter update -> pos1=0 after release and no spurious step_seen.
